// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared half-precision field widths, class codes and pack status
//
// Purpose: common definitions for the fp16 ALU front end (unpack) and back end (pack).
// Contents: field widths, exponent limit, canonical quiet NaN, operand class codes,
//           pack-side status codes, unpacked operand/pair structs, small helper.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int MANT_W = 11;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;
  localparam logic [15:0]      QNAN    = 16'h7E00;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'b000,
    CLS_SUB  = 3'b001,
    CLS_NORM = 3'b010,
    CLS_INF  = 3'b011,
    CLS_NAN  = 3'b100
  } fp_class_e;

  // Result status produced by the exponent check/pack stage.
  typedef enum logic [1:0] {
    PK_ZERO = 2'b00,
    PK_OVF  = 2'b01,
    PK_UNF  = 2'b10,
    PK_NORM = 2'b11
  } pack_status_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    fp_class_e         cls;
  } fp_op_t;

  typedef struct packed {
    fp_op_t      a;
    fp_op_t      b;
    logic        special;
    logic [15:0] nan_word;
  } fp_pair_t;

  function automatic logic is_special(input fp_class_e c);
    return (c == CLS_INF) || (c == CLS_NAN);
  endfunction

endpackage

// File: rtl/fp16_operand_unpack_if.sv
// rtl/fp16_operand_unpack_if.sv - operand-pair input and unpacked-pair output bus
//
// Purpose: groups the input handshake (in_valid/in_ready/a/b) and the output
//          handshake plus unpacked fields (out_valid/out_ready/s*/e*/m*/c*/special/nan_word).
// Modports: slave  - the unpack stage (consumes operands, produces unpacked pair)
//           master - the environment (source of operands, sink of unpacked pair)
interface fp16_operand_unpack_if;
  import fp16_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [15:0]       a;
  logic [15:0]       b;
  logic              out_valid;
  logic              out_ready;
  logic              sa;
  logic              sb;
  logic [EXP_W-1:0]  ea;
  logic [EXP_W-1:0]  eb;
  logic [MANT_W-1:0] ma;
  logic [MANT_W-1:0] mb;
  logic [2:0]        ca;
  logic [2:0]        cb;
  logic              special;
  logic [15:0]       nan_word;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sa, sb, ea, eb, ma, mb, ca, cb, special, nan_word
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sa, sb, ea, eb, ma, mb, ca, cb, special, nan_word
  );

endinterface

// File: rtl/fp16_classify.sv
// rtl/fp16_classify.sv - combinational single-operand unpack and classification
//
// Purpose: split one half-precision word into sign, effective exponent and
//          hidden-bit mantissa, and assign its class code.
// Ports: op_i  - raw operand {sign, exp[4:0], frac[9:0]}
//        unp_o - unpacked operand struct (sign, exp, mant, cls)
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [15:0] op_i,
  output fp_op_t      unp_o
);

  logic [EXP_W-1:0]  exp_raw;
  logic [FRAC_W-1:0] frac;
  logic              exp_zero;
  logic              exp_max;
  logic              frac_zero;

  assign exp_raw   = op_i[14:10];
  assign frac      = op_i[9:0];
  assign exp_zero  = (exp_raw == '0);
  assign exp_max   = (exp_raw == EXP_MAX);
  assign frac_zero = (frac == '0);

  always_comb begin
    unp_o.sign = op_i[15];
    unp_o.mant = {!exp_zero, frac};
    unp_o.exp  = exp_raw;
    unp_o.cls  = CLS_NORM;
    if (exp_zero) begin
      // Subnormals share the exponent of the smallest normal so the datapath
      // can align them without a special case; zero keeps exponent 0.
      unp_o.cls = frac_zero ? CLS_ZERO : CLS_SUB;
      unp_o.exp = frac_zero ? 5'd0 : 5'd1;
    end else if (exp_max) begin
      unp_o.cls = frac_zero ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/fp16_operand_unpack.sv
// rtl/fp16_operand_unpack.sv - fp16 ALU front end: unpack, classify, skid-buffered output
//
// Purpose: accept operand pairs, unpack/classify both operands, present the
//          result one cycle later through an output register backed by a skid
//          register, and keep saturating NaN/inf/subnormal operand counters.
// Ports: clk, rst_n      - clock, synchronous active-low reset
//        bus (slave)     - operand input handshake and unpacked output handshake
//        cnt_clr         - synchronous clear of all counters (wins over increment)
//        nan_cnt/inf_cnt/sub_cnt - saturating operand counts
module fp16_operand_unpack #(
  parameter int          CNT_W = 8,
  parameter logic [15:0] QNAN  = fp16_pkg::QNAN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fp16_operand_unpack_if.slave    bus,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        nan_cnt,
  output logic [CNT_W-1:0]        inf_cnt,
  output logic [CNT_W-1:0]        sub_cnt
);
  import fp16_pkg::*;

  fp_op_t   unp_a;
  fp_op_t   unp_b;
  fp_pair_t pair_new;

  fp_pair_t          out_q;
  logic              out_valid_q;
  fp_pair_t          skid_q;
  logic              skid_valid_q;
  logic              in_ready_q;
  logic [CNT_W-1:0]  nan_cnt_q;
  logic [CNT_W-1:0]  inf_cnt_q;
  logic [CNT_W-1:0]  sub_cnt_q;

  logic              accept;
  logic              out_free;
  logic              skid_valid_d;
  logic [1:0]        nan_inc;
  logic [1:0]        inf_inc;
  logic [1:0]        sub_inc;

  fp16_classify u_cls_a (.op_i(bus.a), .unp_o(unp_a));
  fp16_classify u_cls_b (.op_i(bus.b), .unp_o(unp_b));

  always_comb begin
    pair_new.a        = unp_a;
    pair_new.b        = unp_b;
    pair_new.special  = is_special(unp_a.cls) || is_special(unp_b.cls);
    pair_new.nan_word = ((unp_a.cls == CLS_NAN) || (unp_b.cls == CLS_NAN)) ? QNAN : 16'h0000;
  end

  assign accept   = bus.in_valid && in_ready_q;
  // Output register can take new data when empty or being drained this edge.
  assign out_free = !out_valid_q || bus.out_ready;

  // in_ready is the registered inverse of skid occupancy, so accept never
  // coincides with a full skid; the skid only fills while the output stalls.
  always_comb begin
    skid_valid_d = skid_valid_q;
    if (out_free)
      skid_valid_d = 1'b0;
    else if (accept)
      skid_valid_d = 1'b1;
  end

  assign nan_inc = {1'b0, unp_a.cls == CLS_NAN} + {1'b0, unp_b.cls == CLS_NAN};
  assign inf_inc = {1'b0, unp_a.cls == CLS_INF} + {1'b0, unp_b.cls == CLS_INF};
  assign sub_inc = {1'b0, unp_a.cls == CLS_SUB} + {1'b0, unp_b.cls == CLS_SUB};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      nan_cnt_q    <= '0;
      inf_cnt_q    <= '0;
      sub_cnt_q    <= '0;
    end else begin
      if (out_free) begin
        if (skid_valid_q) begin
          out_q       <= skid_q;
          out_valid_q <= 1'b1;
        end else begin
          if (accept)
            out_q <= pair_new;
          out_valid_q <= accept;
        end
      end else if (accept) begin
        skid_q <= pair_new;
      end
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;

      if (cnt_clr) begin
        nan_cnt_q <= '0;
        inf_cnt_q <= '0;
        sub_cnt_q <= '0;
      end else if (accept) begin
        nan_cnt_q <= sat_add(nan_cnt_q, nan_inc);
        inf_cnt_q <= sat_add(inf_cnt_q, inf_inc);
        sub_cnt_q <= sat_add(sub_cnt_q, sub_inc);
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sa        = out_q.a.sign;
  assign bus.ea        = out_q.a.exp;
  assign bus.ma        = out_q.a.mant;
  assign bus.ca        = out_q.a.cls;
  assign bus.sb        = out_q.b.sign;
  assign bus.eb        = out_q.b.exp;
  assign bus.mb        = out_q.b.mant;
  assign bus.cb        = out_q.b.cls;
  assign bus.special   = out_q.special;
  assign bus.nan_word  = out_q.nan_word;

  assign nan_cnt = nan_cnt_q;
  assign inf_cnt = inf_cnt_q;
  assign sub_cnt = sub_cnt_q;

endmodule

// File: tb/tb_fp16_operand_unpack.sv
// tb/tb_fp16_operand_unpack.sv - directed self-checking bench for fp16_operand_unpack
module tb_fp16_operand_unpack;

  logic       clk;
  logic       rst_n;
  logic       cnt_clr;
  logic [7:0] nan_cnt;
  logic [7:0] inf_cnt;
  logic [7:0] sub_cnt;

  int vectors;
  int miscompares;

  fp16_operand_unpack_if bus ();

  fp16_operand_unpack #(.CNT_W(8), .QNAN(16'h7E00)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .cnt_clr (cnt_clr),
    .nan_cnt (nan_cnt),
    .inf_cnt (inf_cnt),
    .sub_cnt (sub_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fields();
    return {bus.ea, bus.ma, bus.eb, bus.mb};
  endfunction

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    cnt_clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = 16'h0000;
    bus.b        = 16'h0000;
    bus.out_ready = 1'b1;

    step();
    step();
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_fields", fields(), 32'd0);
    chk("rst_cls", {26'd0, bus.ca, bus.cb}, 32'd0);
    chk("rst_cnts", {8'd0, nan_cnt, inf_cnt, sub_cnt}, 32'd0);

    rst_n = 1'b1;
    step();
    chk("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // 1.0 and -2.0
    bus.a = 16'h3C00; bus.b = 16'hC000; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("t1_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t1_signs", {30'd0, bus.sa, bus.sb}, 32'd1);
    chk("t1_fields", fields(), {5'd15, 11'h400, 5'd16, 11'h400});
    chk("t1_cls", {26'd0, bus.ca, bus.cb}, {26'd0, 3'b010, 3'b010});
    chk("t1_special", {15'd0, bus.special, bus.nan_word}, 32'd0);

    // smallest subnormal and zero
    bus.a = 16'h0001; bus.b = 16'h0000; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("t2_fields", fields(), {5'd1, 11'h001, 5'd0, 11'h000});
    chk("t2_cls", {26'd0, bus.ca, bus.cb}, {26'd0, 3'b001, 3'b000});
    chk("t2_sub_cnt", {24'd0, sub_cnt}, 32'd1);

    // infinity and NaN
    bus.a = 16'h7C00; bus.b = 16'h7E01; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("t3_fields", fields(), {5'd31, 11'h400, 5'd31, 11'h601});
    chk("t3_cls", {26'd0, bus.ca, bus.cb}, {26'd0, 3'b011, 3'b100});
    chk("t3_special", {15'd0, bus.special, bus.nan_word}, {15'd0, 1'b1, 16'h7E00});
    chk("t3_cnts", {16'd0, nan_cnt, inf_cnt}, {16'd0, 8'd1, 8'd1});
    step();
    chk("t3_drained", {31'd0, bus.out_valid}, 32'd0);

    // stall: P1 to output, P2 to skid, P3 held by source
    bus.out_ready = 1'b0;
    bus.a = 16'h3C00; bus.b = 16'h4000; bus.in_valid = 1'b1;
    step();
    chk("t4_p1_out", {bus.out_valid, bus.in_ready, 30'd0}, {1'b1, 1'b1, 30'd0});
    bus.a = 16'h4200; bus.b = 16'h4400;
    step();
    chk("t4_skid_full", {31'd0, bus.in_ready}, 32'd0);
    chk("t4_p1_hold", fields(), {5'd15, 11'h400, 5'd16, 11'h400});
    bus.a = 16'h4500; bus.b = 16'h4600;
    step();
    chk("t4_still_full", {31'd0, bus.in_ready}, 32'd0);
    chk("t4_p1_hold2", fields(), {5'd15, 11'h400, 5'd16, 11'h400});
    bus.out_ready = 1'b1;
    step();
    chk("t4_p2_out", fields(), {5'd16, 11'h600, 5'd17, 11'h400});
    chk("t4_ready_back", {30'd0, bus.out_valid, bus.in_ready}, 32'd3);
    step();
    bus.in_valid = 1'b0;
    chk("t4_p3_out", fields(), {5'd17, 11'h500, 5'd17, 11'h600});
    chk("t4_p3_valid", {31'd0, bus.out_valid}, 32'd1);
    step();
    chk("t4_empty", {31'd0, bus.out_valid}, 32'd0);

    // NaN counter saturation, then clear wins over increment
    bus.a = 16'h7E00; bus.b = 16'h7E00; bus.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) step();
    chk("t5_nan_sat", {24'd0, nan_cnt}, 32'd255);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    bus.in_valid = 1'b0;
    chk("t5_nan_clr", {24'd0, nan_cnt}, 32'd0);
    chk("t5_inf_clr", {24'd0, inf_cnt}, 32'd0);
    step();

    // reset with skid full and output valid
    bus.out_ready = 1'b0;
    bus.a = 16'h7E00; bus.b = 16'h7C00; bus.in_valid = 1'b1;
    step();
    step();
    chk("t6_pre_full", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
    chk("t6_pre_cnts", {16'd0, nan_cnt, inf_cnt}, {16'd0, 8'd2, 8'd2});
    rst_n = 1'b0;
    step();
    chk("t6_rst_hs", {30'd0, bus.out_valid, bus.in_ready}, 32'd0);
    chk("t6_rst_fields", fields(), 32'd0);
    chk("t6_rst_special", {12'd0, bus.ca, bus.special, bus.nan_word}, 32'd0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    step();
    chk("t6_rel_hs", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    chk("t6_rel_cnts", {8'd0, nan_cnt, inf_cnt, sub_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
